// File: rtl/line_fill_mem.sv
// Purpose : main-memory responder below the cache; serves 4-word blocks on two
//           independent ports (port 1 read-only fills, port 2 reads/write-backs).
// Latency : fixed LATENCY cycles from request acceptance to the 1-cycle response pulse.
// Backpr. : none; requests arriving while a port is busy are dropped, so the
//           requester holds its request until it sees the response pulse.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   i_valid1/i_read_m1           port-1 read request
//   i_address1                   port-1 word address ([1:0] ignored)
//   o_data1/o_inputReady1        port-1 block data (word0 in [W-1:0]) and valid pulse
//   i_valid2/i_read_m2/i_write_m2 port-2 request (read+write together = write)
//   i_address2                   port-2 word address ([1:0] ignored)
//   io_data2                     port-2 block data: sampled on write accept, driven in read RESP
//   o_inputReady2/o_ackOutput2   port-2 read-data-valid / write-committed pulses
module line_fill_mem #(
  parameter int LATENCY    = 4,   // 1..15
  parameter int MEM_BLOCKS = 64,
  parameter int WORD_SIZE  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_valid1,
  input  logic                   i_read_m1,
  input  logic [15:0]            i_address1,
  output logic [4*WORD_SIZE-1:0] o_data1,
  output logic                   o_inputReady1,
  input  logic                   i_valid2,
  input  logic                   i_read_m2,
  input  logic                   i_write_m2,
  input  logic [15:0]            i_address2,
  inout  wire  [4*WORD_SIZE-1:0] io_data2,
  output logic                   o_inputReady2,
  output logic                   o_ackOutput2
);

  localparam int BW   = 4 * WORD_SIZE;
  localparam int IDXW = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  // Block index = word address / 4, wrapped into the array.
  function automatic logic [IDXW-1:0] blk_idx(input logic [13:0] blk);
    return IDXW'(32'(blk) % MEM_BLOCKS);
  endfunction

  logic [BW-1:0] r_mem [MEM_BLOCKS];

  // Word-select bits are irrelevant for whole-block transfers.
  logic w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^{i_address1[1:0], i_address2[1:0]};

  // ------------------------------------------------------------------
  // Port 1 (read only)
  // ------------------------------------------------------------------
  state_t          r_st1, w_nxt1;
  logic [3:0]      r_cnt1;
  logic [IDXW-1:0] r_idx1;
  logic [BW-1:0]   r_data1;
  logic            w_acc1;
  logic            w_enter_resp1;
  logic [IDXW-1:0] w_ridx1;

  assign w_acc1        = (r_st1 == S_IDLE) && i_valid1 && i_read_m1;
  assign w_enter_resp1 = (w_nxt1 == S_RESP) && (r_st1 != S_RESP);
  // With LATENCY=1 the capture happens on the accept edge, before the
  // index register has been loaded, so take the index straight from the port.
  assign w_ridx1       = (r_st1 == S_IDLE) ? blk_idx(i_address1[15:2]) : r_idx1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_st1   <= S_IDLE;
      r_cnt1  <= '0;
      r_idx1  <= '0;
      r_data1 <= '0;
    end else begin
      r_st1 <= w_nxt1;
      if (w_acc1) begin
        r_idx1 <= blk_idx(i_address1[15:2]);
        r_cnt1 <= 4'(LATENCY - 1);
      end else if (r_st1 == S_BUSY) begin
        r_cnt1 <= r_cnt1 - 4'd1;
      end
      // Nonblocking read of r_mem: a port-2 commit on this same edge is not
      // yet visible, so a colliding read returns the pre-write block.
      if (w_enter_resp1) r_data1 <= r_mem[w_ridx1];
    end
  end

  // BUSY is left on the edge where the counter reaches zero (it is 1 before
  // that edge); counter load of LATENCY-1 then yields LATENCY cycles total.
  always_comb begin
    w_nxt1 = r_st1;
    case (r_st1)
      S_IDLE:  if (w_acc1) w_nxt1 = (LATENCY == 1) ? S_RESP : S_BUSY;
      S_BUSY:  if (r_cnt1 == 4'd1) w_nxt1 = S_RESP;
      S_RESP:  w_nxt1 = S_IDLE;
      default: w_nxt1 = S_IDLE;
    endcase
  end

  always_comb begin
    o_inputReady1 = (r_st1 == S_RESP);
    o_data1       = r_data1;
  end

  // ------------------------------------------------------------------
  // Port 2 (block read / block write-back)
  // ------------------------------------------------------------------
  state_t          r_st2, w_nxt2;
  logic [3:0]      r_cnt2;
  logic [IDXW-1:0] r_idx2;
  logic            r_wr2;
  logic [BW-1:0]   r_wdat2;
  logic [BW-1:0]   r_rdat2;
  logic            w_acc2;
  logic            w_enter_resp2;
  logic            w_op_wr2;
  logic [IDXW-1:0] w_idx2;
  logic [BW-1:0]   w_wdat2;
  logic            w_commit2;
  logic            w_drv2;

  assign w_acc2        = (r_st2 == S_IDLE) && i_valid2 && (i_read_m2 || i_write_m2);
  assign w_enter_resp2 = (w_nxt2 == S_RESP) && (r_st2 != S_RESP);
  // Same LATENCY=1 bypass as port 1: op, index and data come from the port
  // when the commit/capture coincides with acceptance.
  assign w_op_wr2      = (r_st2 == S_IDLE) ? i_write_m2 : r_wr2;
  assign w_idx2        = (r_st2 == S_IDLE) ? blk_idx(i_address2[15:2]) : r_idx2;
  assign w_wdat2       = (r_st2 == S_IDLE) ? io_data2 : r_wdat2;
  // Gated by reset_n so a reset edge aborts a pending write-back.
  assign w_commit2     = reset_n && w_enter_resp2 && w_op_wr2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_st2   <= S_IDLE;
      r_cnt2  <= '0;
      r_idx2  <= '0;
      r_wr2   <= 1'b0;
      r_wdat2 <= '0;
      r_rdat2 <= '0;
    end else begin
      r_st2 <= w_nxt2;
      if (w_acc2) begin
        r_idx2  <= blk_idx(i_address2[15:2]);
        r_wr2   <= i_write_m2;          // read+write together counts as write
        r_wdat2 <= io_data2;
        r_cnt2  <= 4'(LATENCY - 1);
      end else if (r_st2 == S_BUSY) begin
        r_cnt2 <= r_cnt2 - 4'd1;
      end
      if (w_enter_resp2 && !w_op_wr2) r_rdat2 <= r_mem[w_idx2];
    end
  end

  always_comb begin
    w_nxt2 = r_st2;
    case (r_st2)
      S_IDLE:  if (w_acc2) w_nxt2 = (LATENCY == 1) ? S_RESP : S_BUSY;
      S_BUSY:  if (r_cnt2 == 4'd1) w_nxt2 = S_RESP;
      S_RESP:  w_nxt2 = S_IDLE;
      default: w_nxt2 = S_IDLE;
    endcase
  end

  always_comb begin
    o_inputReady2 = (r_st2 == S_RESP) && !r_wr2;
    o_ackOutput2  = (r_st2 == S_RESP) &&  r_wr2;
    w_drv2        = (r_st2 == S_RESP) && !r_wr2;
  end

  assign io_data2 = w_drv2 ? r_rdat2 : {BW{1'bz}};

  // ------------------------------------------------------------------
  // Block storage (not cleared by reset)
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_commit2) r_mem[w_idx2] <= w_wdat2;
  end

endmodule
